// File: rtl/t03_nes_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : t03_nes_pkg                                                     |
// | Brief    : Shared constants and FSM state type for the NES pad responder.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package t03_nes_pkg;

    localparam int NES_BITS = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } nes_resp_state_t;

endpackage
`default_nettype wire

// File: rtl/t03_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : t03_sync_edge                                                   |
// | Brief    : Multi-flop synchronizer with rise/fall detect on the last stage.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module t03_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic async_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_last;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync <= '0;
            r_last <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_in};
            r_last <= r_sync[STAGES-1];
        end
    end

    assign sync = r_sync[STAGES-1];
    assign rise = r_sync[STAGES-1] & ~r_last;
    assign fall = ~r_sync[STAGES-1] & r_last;

endmodule
`default_nettype wire

// File: rtl/t03_nes_controller_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : t03_nes_controller_responder                                    |
// | Brief    : 4021-style NES pad emulation answering a host latch/pulse poll. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module t03_nes_controller_responder
    import t03_nes_pkg::*;
#(
    parameter int   N_BITS      = NES_BITS,
    parameter int   SYNC_STAGES = 2,
    parameter logic FILL_LEVEL  = 1'b0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [N_BITS-1:0] buttons,
    input  logic              latch_in,
    input  logic              pulse_in,
    output logic              data_out,
    output logic [3:0]        bit_idx,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [1:0]        state_o
);

    localparam logic [1:0] C_ST_IDLE  = IDLE;
    localparam logic [1:0] C_ST_LOAD  = LOAD;
    localparam logic [1:0] C_ST_SHIFT = SHIFT;
    localparam logic [1:0] C_ST_DONE  = DONE;
    localparam logic [3:0] C_LAST_IDX = 4'(N_BITS - 1);

    logic                                r_state_dummy_unused;
    logic [1:0]                          r_state;
    logic [N_BITS-1:0]                   r_shreg;
    logic [3:0]                          r_bit_idx;
    logic                                r_done;
    logic                                r_abort;
    logic [SYNC_STAGES-1:0][N_BITS-1:0]  r_btn_sync;

    logic              w_latch_s, w_latch_rise, w_latch_fall;
    logic              w_pulse_s, w_pulse_rise, w_pulse_fall;
    logic [N_BITS-1:0] w_btn_s;
    logic              w_unused;

    t03_sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
        .clk      (clk),
        .nrst     (nrst),
        .async_in (latch_in),
        .sync     (w_latch_s),
        .rise     (w_latch_rise),
        .fall     (w_latch_fall)
    );

    t03_sync_edge #(.STAGES(SYNC_STAGES)) u_pulse_sync (
        .clk      (clk),
        .nrst     (nrst),
        .async_in (pulse_in),
        .sync     (w_pulse_s),
        .rise     (w_pulse_rise),
        .fall     (w_pulse_fall)
    );

    assign w_unused = ^{w_pulse_s, w_pulse_fall, r_state_dummy_unused};

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_btn_sync           <= '0;
            r_state_dummy_unused <= 1'b0;
        end else begin
            r_btn_sync           <= {r_btn_sync[SYNC_STAGES-2:0], buttons};
            r_state_dummy_unused <= 1'b0;
        end
    end

    assign w_btn_s = r_btn_sync[SYNC_STAGES-1];

    // Latch takes priority over pulse everywhere, so a coincident pulse never shifts.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= C_ST_IDLE;
            r_shreg   <= '1;
            r_bit_idx <= 4'd0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                C_ST_IDLE: begin
                    if (w_latch_s) r_state <= C_ST_LOAD;
                end
                C_ST_LOAD: begin
                    r_shreg   <= ~w_btn_s;
                    r_bit_idx <= 4'd0;
                    if (w_latch_fall) r_state <= C_ST_SHIFT;
                end
                C_ST_SHIFT: begin
                    if (w_latch_rise) begin
                        r_state   <= C_ST_LOAD;
                        r_bit_idx <= 4'd0;
                        r_abort   <= 1'b1;
                    end else if (w_pulse_rise && !w_latch_s) begin
                        r_shreg   <= {FILL_LEVEL, r_shreg[N_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (r_bit_idx == C_LAST_IDX) begin
                            r_state <= C_ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                C_ST_DONE: begin
                    if (w_latch_rise) begin
                        r_state   <= C_ST_LOAD;
                        r_bit_idx <= 4'd0;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

    assign data_out    = r_shreg[0];
    assign bit_idx     = r_bit_idx;
    assign frame_done  = r_done;
    assign frame_abort = r_abort;
    assign state_o     = r_state;

endmodule
`default_nettype wire
